// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 master: one 32-bit NOR/SRAM read or write per request.
// Define SPI_FAST_READ_EN for 0Bh fast reads with 8 dummy clocks.
module spi_mem_ctrl #(
  parameter int         CLK_DIV   = 2,
  parameter logic [7:0] READ_CMD  = 8'h03,
  parameter logic [7:0] WRITE_CMD = 8'h02
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GUARD
  } state_t;

  localparam logic [8:0] DIV_M1 = 9'(CLK_DIV - 1);
  localparam logic [8:0] GRD_M1 = 9'(2 * CLK_DIV - 1);
  localparam logic [6:0] WR_LAST = 7'd63;

`ifdef SPI_FAST_READ_EN
  localparam int         SR_W    = 72;
  localparam logic [7:0] RD_OP   = 8'h0B;
  localparam logic [6:0] RD_LAST = 7'd71;
`else
  localparam int         SR_W    = 64;
  localparam logic [7:0] RD_OP   = READ_CMD;
  localparam logic [6:0] RD_LAST = 7'd63;
`endif

  state_t          state;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] frame;
  logic [31:0]     rx;
  logic [31:0]     wbytes;
  logic [8:0]      cnt;
  logic [6:0]      bit_cnt;
  logic [6:0]      last;
  logic            we_q;

  // Data goes out little-endian by byte, each byte MSB first.
  assign wbytes = {wdata[7:0], wdata[15:8],
                   wdata[23:16], wdata[31:24]};

`ifdef SPI_FAST_READ_EN
  assign frame = we ? {WRITE_CMD, addr, wbytes, 8'h00}
                    : {RD_OP, addr, 40'h0};
`else
  assign frame = we ? {WRITE_CMD, addr, wbytes}
                    : {RD_OP, addr, 32'h0};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      rx       <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      last     <= '0;
      we_q     <= 1'b0;
      rdata    <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q     <= we;
            sr       <= frame;
            last     <= we ? WR_LAST : RD_LAST;
            cnt      <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_mosi <= frame[SR_W-1];
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == DIV_M1) begin
            cnt      <= '0;
            spi_sclk <= ~spi_sclk;
            if (!spi_sclk) begin
              rx <= {rx[30:0], spi_miso};
            end else if (bit_cnt == last) begin
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              ready    <= 1'b1;
              if (!we_q)
                rdata <= {rx[7:0], rx[15:8],
                          rx[23:16], rx[31:24]};
              state <= GUARD;
            end else begin
              bit_cnt  <= bit_cnt + 7'd1;
              sr       <= {sr[SR_W-2:0], 1'b0};
              spi_mosi <= sr[SR_W-2];
            end
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        GUARD: begin
          if (cnt == GRD_M1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Randomised bench for spi_mem_ctrl at CLK_DIV=2 and CLK_DIV=1,
// checked each cycle against a frame-level model.
module tb_spi_mem_ctrl;

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] RD_OP = 8'h0B;
  localparam int RD_LAT2   = 288;
  localparam int RD_LAT1   = 144;
  localparam int RD_PULSES = 72;
`else
  localparam logic [7:0] RD_OP = 8'h03;
  localparam int RD_LAT2   = 256;
  localparam int RD_LAT1   = 128;
  localparam int RD_PULSES = 64;
`endif
  localparam int WR_LAT2 = 256;
  localparam int WR_LAT1 = 128;

  logic        clk = 1'b0;
  logic [1:0]  rst = 2'b11;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [1:0]  miso = 2'b00;
  logic [1:0]  ready, busy, sclk, cs_n, mosi;
  logic [23:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          m_act [2];
  int          m_k [2];
  int          m_n [2];
  bit          m_we [2];
  logic [31:0] m_rdata [2];
  logic [31:0] m_exp_rd [2];
  logic [31:0] nxt_slave [2];
  bit          ebits [2][72];
  bit          mbits [2][72];

  int          acc_cyc [2];
  int          rdy_cyc [2];
  int          rdy_cnt [2];
  int          fall_cyc [2];
  int          pulses [2];
  logic [71:0] obs [2];
  logic [1:0]  prev_cs = 2'b11;
  logic [1:0]  prev_sclk = 2'b00;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.CLK_DIV(2)) u_d2 (
    .clk(clk), .reset(rst[0]), .req(req[0]),
    .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]),
    .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_mem_ctrl #(.CLK_DIV(1)) u_d1 (
    .clk(clk), .reset(rst[1]), .req(req[1]),
    .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]),
    .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Build the expected wire frame and slave response for one request.
  task automatic start(input int i);
    logic [7:0] bq [$];
    int n;
    bq = {};
    m_we[i] = we[i];
    bq.push_back(we[i] ? 8'h02 : RD_OP);
    bq.push_back(addr[i][23:16]);
    bq.push_back(addr[i][15:8]);
    bq.push_back(addr[i][7:0]);
`ifdef SPI_FAST_READ_EN
    if (!we[i]) bq.push_back(8'h00);
`endif
    for (int b = 0; b < 4; b++)
      bq.push_back(we[i] ? wdata[i][8*b +: 8] : 8'h00);
    n = 0;
    foreach (bq[b])
      for (int j = 7; j >= 0; j--) begin
        ebits[i][n] = bq[b][j];
        n++;
      end
    m_n[i] = n;
    for (int p = 0; p < n - 32; p++)
      mbits[i][p] = 1'($urandom_range(0, 1));
    for (int q = 0; q < 32; q++)
      mbits[i][n-32+q] = nxt_slave[i][31-q];
    for (int b = 0; b < 4; b++)
      m_exp_rd[i][8*b +: 8] = nxt_slave[i][31-8*b -: 8];
    m_act[i]   = 1'b1;
    m_k[i]     = 0;
    acc_cyc[i] = cyc;
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_act[i]   = 1'b0;
        m_rdata[i] = '0;
      end else if (!m_act[i]) begin
        if (req[i]) start(i);
      end else begin
        m_k[i]++;
        if (m_k[i] == 2*m_n[i]*dv(i) && !m_we[i])
          m_rdata[i] = m_exp_rd[i];
        if (m_k[i] == 2*(m_n[i]+1)*dv(i))
          m_act[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d;
      int t;
      logic [3:0]  ectl;
      logic [31:0] erd;
      d = dv(i);
      t = 2*m_n[i]*d;
      erd = m_rdata[i];
      if (rst[i]) begin
        ectl = 4'b1000;
        erd  = '0;
      end else if (!m_act[i]) begin
        ectl = 4'b1000;
      end else if (m_k[i] < t) begin
        ectl = {1'b0, 1'((m_k[i]/d) % 2), 2'b10};
        chk($sformatf("mosi%0d", i), 72'(mosi[i]),
            72'(ebits[i][m_k[i]/(2*d)]));
      end else if (m_k[i] == t) begin
        ectl = 4'b1011;
      end else begin
        ectl = 4'b1010;
      end
      chk($sformatf("ctl%0d", i),
          72'({cs_n[i], sclk[i], busy[i], ready[i]}),
          72'(ectl));
      chk($sformatf("rdata%0d", i), 72'(rdata[i]), 72'(erd));
      if (ready[i]) begin
        rdy_cnt[i]++;
        rdy_cyc[i] = cyc;
      end
      if (prev_cs[i] && !cs_n[i]) fall_cyc[i] = cyc;
      if (!prev_sclk[i] && sclk[i]) begin
        pulses[i]++;
        obs[i] = {obs[i][70:0], mosi[i]};
      end
      prev_cs[i]   = cs_n[i];
      prev_sclk[i] = sclk[i];
      miso[i] = (!rst[i] && m_act[i] && m_k[i] < t)
              ? mbits[i][m_k[i]/(2*d)] : 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int i);
    int c;
    c = 0;
    while (m_act[i] && c < 1000) begin
      tick();
      c++;
    end
    if (m_act[i]) chk("idle_timeout", 72'(m_act[i]), 72'(0));
  endtask

  task automatic run(input int i, input bit w,
                     input logic [23:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] sl,
                     output int lat);
    int r0;
    int c;
    wait_idle(i);
    we[i] = w;
    addr[i] = a;
    wdata[i] = wd;
    nxt_slave[i] = sl;
    obs[i] = '0;
    pulses[i] = 0;
    r0 = rdy_cnt[i];
    req[i] = 1'b1;
    tick();
    req[i] = 1'b0;
    c = 0;
    while (rdy_cnt[i] == r0 && c < 1000) begin
      tick();
      c++;
    end
    lat = rdy_cyc[i] - acc_cyc[i];
    wait_idle(i);
    chk($sformatf("ready_once%0d", i), 72'(rdy_cnt[i] - r0), 72'(1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r0;
    int c;
    int first;
    bit w;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
      nxt_slave[i] = '0;
      rdy_cnt[i] = 0;
      pulses[i] = 0;
      obs[i] = '0;
      fall_cyc[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_state%0d", i),
          72'({rdata[i], ready[i], busy[i], sclk[i], cs_n[i], mosi[i]}),
          72'({32'h0, 5'b00010}));
    rst = 2'b00;
    tick();

    run(0, 1'b0, 24'h001234, 32'h0, 32'hEFBEADDE, lat);
    chk("rd_lat", 72'(lat), 72'(RD_LAT2));
    chk("rd_data", 72'(rdata[0]), 72'(32'hDEADBEEF));
    chk("rd_hdr", 72'(32'(obs[0] >> (RD_PULSES - 32))),
        72'({RD_OP, 24'h001234}));
    chk("rd_pulses", 72'(pulses[0]), 72'(RD_PULSES));

    run(0, 1'b1, 24'hABCDEF, 32'h11223344, $urandom, lat);
    chk("wr_lat", 72'(lat), 72'(WR_LAT2));
    chk("wr_frame", 72'(obs[0][63:0]), 72'(64'h02ABCDEF44332211));
    chk("wr_rdata_kept", 72'(rdata[0]), 72'(32'hDEADBEEF));

    // Back-to-back reads with req held high throughout.
    wait_idle(0);
    we[0] = 1'b0;
    addr[0] = 24'h000100;
    nxt_slave[0] = 32'h01020304;
    r0 = rdy_cnt[0];
    first = -1;
    req[0] = 1'b1;
    c = 0;
    while (rdy_cnt[0] < r0 + 2 && c < 2000) begin
      tick();
      c++;
      if (rdy_cnt[0] == r0 + 1 && first < 0) first = rdy_cyc[0];
    end
    req[0] = 1'b0;
    chk("b2b_count", 72'(rdy_cnt[0] - r0), 72'(2));
    chk("b2b_gap", 72'(fall_cyc[0] - first), 72'(5));
    chk("b2b_rdata", 72'(rdata[0]), 72'(32'h04030201));

    // Reset in the middle of a read.
    wait_idle(0);
    we[0] = 1'b0;
    addr[0] = 24'h00ABCD;
    nxt_slave[0] = 32'h55AA55AA;
    r0 = rdy_cnt[0];
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    repeat (49) tick();
    rst[0] = 1'b1;
    #1;
    chk("rst_async", 72'({cs_n[0], sclk[0], busy[0]}), 72'(3'b100));
    repeat (3) tick();
    rst[0] = 1'b0;
    repeat (300) tick();
    chk("rst_no_ready", 72'(rdy_cnt[0] - r0), 72'(0));
    run(0, 1'b0, 24'h003456, 32'h0, 32'hCAFEF00D, lat);
    chk("rst_next_lat", 72'(lat), 72'(RD_LAT2));
    chk("rst_next_data", 72'(rdata[0]), 72'(32'h0DF0FECA));

    for (int n = 0; n < 20; n++) begin
      w = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      run(0, w, 24'($urandom), $urandom, $urandom, lat);
      chk("rnd_lat2", 72'(lat), 72'(w ? WR_LAT2 : RD_LAT2));
    end

    run(1, 1'b0, 24'hFFFFFC, 32'h0, 32'h5AC30F96, lat);
    chk("d1_rd_lat", 72'(lat), 72'(RD_LAT1));
    chk("d1_pulses", 72'(pulses[1]), 72'(RD_PULSES));
    chk("d1_rdata", 72'(rdata[1]), 72'(32'h960FC35A));
    chk("d1_hdr", 72'(32'(obs[1] >> (RD_PULSES - 32))),
        72'({RD_OP, 24'hFFFFFC}));

    run(1, 1'b1, 24'h000000, 32'hA5A5F00F, $urandom, lat);
    chk("d1_wr_lat", 72'(lat), 72'(WR_LAT1));
    chk("d1_wr_frame", 72'(obs[1][63:0]), 72'(64'h020000000FF0A5A5));

    for (int n = 0; n < 10; n++) begin
      w = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
      run(1, w, 24'($urandom), $urandom, $urandom, lat);
      chk("rnd_lat1", 72'(lat), 72'(w ? WR_LAT1 : RD_LAT1));
    end

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
